simpleserial_host: RTL and testbench
====================================

# simpleserial_host

Host-side (initiator) engine for the SimpleSerial v1.0 ASCII protocol. It drives a byte-wide UART transmitter/receiver pair and sends `k<32 hex>\n` key loads and `p<32 hex>\n` plaintext loads to an AES target. It then parses the target's `r<32 hex>\n` response into a 128-bit ciphertext. It sits between a capture/test controller and the UART cores, so fabric logic can exercise a SimpleSerial AES target without software.

## Interface
Parameters:
- RESP_TIMEOUT, 24'd1_000_000, clock cycles allowed from entering response wait to completion of the response.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- key  in  128  key to send; sampled when load_key is accepted.
- load_key  in  1  request: send key command.
- pt  in  128  plaintext to send; sampled when start is accepted.
- start  in  1  request: send plaintext command, then await response.
- busy  out  1  high while a transaction is pending or in progress.
- ct  out  128  last successfully received ciphertext.
- ct_valid  out  1  one-cycle pulse when ct updates.
- err  out  1  one-cycle pulse on response failure.
- err_code  out  2  1 = bad hex digit, 2 = missing newline, 3 = timeout; held until the next err.
- tx_data  out  8  byte to transmitter; stable while tx_start is high.
- tx_start  out  1  one-cycle transmit strobe.
- tx_busy  in  1  transmitter busy.
- rx_data  in  8  received byte.
- rx_ready  in  1  one-cycle strobe; rx_data is valid when high.

## Operation
- Requests are accepted only in IDLE (busy=0). Requests while busy are ignored.
- If load_key and start are both high in the same cycle, both are accepted. The key command is sent first, then the pt command immediately after. busy stays high throughout.
- Command frame, 34 bytes: command char ('k'=0x6B, 'p'=0x70), then 32 hex chars, then 0x0A.
  - Hex chars are sent MSB nibble first: byte i (1..32) encodes data[127-4(i-1) -: 4].
  - Digits are lowercase: 0-9 → 0x30-0x39, a-f → 0x61-0x66.
- States:
  - IDLE
  - TX_BYTE: wait for tx_busy=0, then pulse tx_start.
  - TX_GAP: one cycle, tx_busy not sampled.
  - RX_WAIT_R
  - RX_HEX
  - RX_NL
- Transmit flow: TX_BYTE → TX_GAP → TX_BYTE until byte 33 (0x0A) is sent.
  - After the key frame: go to the pending pt frame, else IDLE.
  - After the pt frame: go to RX_WAIT_R.
- RX_WAIT_R: bytes other than 'r' (0x72) are discarded. On 'r', go to RX_HEX.
- RX_HEX: accepts '0'-'9', 'a'-'f', 'A'-'F'. Nibbles fill a shadow register MSB first.
  - Any other byte: err, err_code=1, go to IDLE.
  - After 32 nibbles, go to RX_NL.
- RX_NL:
  - 0x0A: copy shadow to ct, pulse ct_valid, go to IDLE.
  - Any other byte: err, err_code=2, go to IDLE.
- Timeout: the counter clears on entry to RX_WAIT_R and increments each cycle in the RX states.
  - At count == RESP_TIMEOUT-1 with no completion: err, err_code=3, go to IDLE.
  - A completing byte in that same cycle wins over the timeout.
- rx_ready is ignored in IDLE and in the TX states.
- ct changes only on successful completion. A failed response leaves the previous ct intact.

## Timing
- Reset values: busy=0, ct=0, ct_valid=0, err=0, err_code=0, tx_data=0, tx_start=0. State is IDLE, counters are 0, any pending pt is cleared.
- Reset asserted mid-transaction: the frame is abandoned and tx_start drops asynchronously. After reset release, no bytes are sent until a new request arrives.
- Request accepted in cycle N:
  - busy=1 from N+1.
  - First tx_start no earlier than N+1, with tx_data = command char in the same cycle.
- tx_start is never high in two consecutive cycles. At least one TX_GAP cycle separates a strobe from the next tx_busy sample.
- Key-only transaction: busy falls the cycle after the final 0x0A strobe.
- Pt transaction: busy falls in the same cycle ct_valid or err pulses. A new request is accepted in that same cycle.
- Receive latency: ct_valid pulses one cycle after the rx_ready carrying 0x0A.
- ct_valid and err are never high together.

## Test plan
- Key load: load_key with key=000102…0f and tx_busy modelled as 10 cycles after each strobe → exactly 34 strobes carrying "k000102030405060708090a0b0c0d0e0f\n"; busy=0 afterwards; ct_valid never pulses.
- Encrypt round trip: start with pt=00112233…ff; reply "r69c4e0d86a7b0430d8cdb78070b4c55a\n" → tx stream "p00112233445566778899aabbccddeeff\n"; ct=69c4e0d8…c55a; one ct_valid pulse.
- Simultaneous load_key and start → k frame fully sent before p frame; single busy interval; correct ct after the reply.
- Errors:
  - Reply "r12G…" → err with err_code=1.
  - 32 valid nibbles followed by 'x' → err with err_code=2.
  - No reply for RESP_TIMEOUT cycles → err with err_code=3.
  - In all three cases ct keeps the prior value.
- Reply "zz\nr" followed by 32 uppercase digits and '\n' → leading bytes ignored, ct decoded correctly; rx_ready pulses during TX are ignored.
- Assert rst_n low at byte 12 of a p frame → tx_start low immediately; all outputs at reset values; a new start afterwards completes normally.

Source files
------------

// File: rtl/simpleserial_host.sv
// SimpleSerial v1.0 host engine: sends k/p command frames through a byte UART
// and parses the target's r<32 hex>\n reply into a 128-bit ciphertext.
module simpleserial_host #(
  parameter logic [23:0] RESP_TIMEOUT = 24'd1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         load_key,
  input  logic [127:0] pt,
  input  logic         start,
  output logic         busy,
  output logic [127:0] ct,
  output logic         ct_valid,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  input  logic [7:0]   rx_data,
  input  logic         rx_ready
);

  typedef enum logic [2:0] {
    IDLE, TX_BYTE, TX_GAP, RX_WAIT_R, RX_HEX, RX_NL
  } state_t;

  state_t         state, state_n;
  logic [5:0]     byte_idx;
  logic [127:0]   shift;
  logic [127:0]   pt_hold;
  logic           is_key;
  logic           pend;
  logic [127:0]   shadow;
  logic [4:0]     nib_cnt;
  logic [23:0]    timer;
  logic [7:0]     cur_byte;
  logic           rx_hex_ok;
  logic [3:0]     rx_nib;
  logic           rx_state;
  logic           accept;
  logic           done_set;
  logic           err_set;
  logic [1:0]     err_code_n;

  assign busy     = (state != IDLE);
  assign rx_state = (state == RX_WAIT_R) || (state == RX_HEX) || (state == RX_NL);

  // Byte to transmit: command char, lowercase hex of the top nibble, or newline
  always_comb begin
    if (byte_idx == 6'd0)
      cur_byte = is_key ? 8'h6B : 8'h70;
    else if (byte_idx == 6'd33)
      cur_byte = 8'h0A;
    else if (shift[127:124] < 4'd10)
      cur_byte = {4'h3, shift[127:124]};
    else
      cur_byte = {4'h6, shift[127:124] - 4'd9};
  end

  // Decode an incoming ASCII hex digit of either case into a nibble
  always_comb begin
    rx_hex_ok = 1'b1;
    rx_nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      rx_nib = rx_data[3:0];
    else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
             (rx_data >= 8'h41 && rx_data <= 8'h46))
      rx_nib = rx_data[3:0] + 4'd9;
    else
      rx_hex_ok = 1'b0;
  end

  // State register; reset abandons any frame so tx_start drops immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and strobe logic; a good newline beats a simultaneous timeout
  always_comb begin
    state_n    = state;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    accept     = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    err_code_n = 2'd0;
    case (state)
      IDLE: begin
        if (load_key || start) begin
          accept  = 1'b1;
          state_n = TX_BYTE;
        end
      end
      TX_BYTE: begin
        tx_data = cur_byte;
        if (!tx_busy) begin
          tx_start = 1'b1;
          if (byte_idx == 6'd33) begin
            if (!is_key)   state_n = RX_WAIT_R;
            else if (pend) state_n = TX_GAP;
            else           state_n = IDLE;
          end else begin
            state_n = TX_GAP;
          end
        end
      end
      TX_GAP: state_n = TX_BYTE;
      RX_WAIT_R: begin
        if (rx_ready && rx_data == 8'h72) state_n = RX_HEX;
      end
      RX_HEX: begin
        if (rx_ready) begin
          if (!rx_hex_ok) begin
            err_set    = 1'b1;
            err_code_n = 2'd1;
            state_n    = IDLE;
          end else if (nib_cnt == 5'd31) begin
            state_n = RX_NL;
          end
        end
      end
      RX_NL: begin
        if (rx_ready) begin
          if (rx_data == 8'h0A) begin
            done_set = 1'b1;
            state_n  = IDLE;
          end else begin
            err_set    = 1'b1;
            err_code_n = 2'd2;
            state_n    = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (rx_state && timer == RESP_TIMEOUT - 24'd1 && !done_set && !err_set) begin
      err_set    = 1'b1;
      err_code_n = 2'd3;
      state_n    = IDLE;
    end
  end

  // Datapath: request capture, frame sequencing, reply shadowing and result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= 6'd0;
      shift    <= 128'd0;
      pt_hold  <= 128'd0;
      is_key   <= 1'b0;
      pend     <= 1'b0;
      shadow   <= 128'd0;
      nib_cnt  <= 5'd0;
      timer    <= 24'd0;
      ct       <= 128'd0;
      ct_valid <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      ct_valid <= done_set;
      err      <= err_set;
      if (err_set)  err_code <= err_code_n;
      if (done_set) ct       <= shadow;
      case (state)
        IDLE: begin
          if (accept) begin
            byte_idx <= 6'd0;
            if (load_key) begin
              shift   <= key;
              is_key  <= 1'b1;
              pend    <= start;
              pt_hold <= pt;
            end else begin
              shift  <= pt;
              is_key <= 1'b0;
              pend   <= 1'b0;
            end
          end
        end
        TX_BYTE: begin
          if (tx_start) begin
            if (byte_idx == 6'd33) begin
              byte_idx <= 6'd0;
              timer    <= 24'd0;
              if (is_key && pend) begin
                shift  <= pt_hold;
                is_key <= 1'b0;
                pend   <= 1'b0;
              end
            end else begin
              byte_idx <= byte_idx + 6'd1;
              if (byte_idx != 6'd0) shift <= {shift[123:0], 4'h0};
            end
          end
        end
        RX_WAIT_R, RX_HEX, RX_NL: begin
          timer <= timer + 24'd1;
          if (state == RX_WAIT_R) nib_cnt <= 5'd0;
          if (state == RX_HEX && rx_ready && rx_hex_ok) begin
            shadow  <= {shadow[123:0], rx_nib};
            nib_cnt <= nib_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simpleserial_host.sv
// Scoreboard bench for simpleserial_host: directed frames and replies with
// hand-written expected byte streams and ciphertexts.
module tb_simpleserial_host;

  localparam logic [23:0]  RT   = 24'd400;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2  = 128'h0123456789abcdeffedcba9876543210;

  typedef struct {
    logic         is_err;
    logic [1:0]   code;
    logic [127:0] ct;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key, pt;
  logic         load_key, start;
  logic         busy;
  logic [127:0] ct;
  logic         ct_valid, err;
  logic [1:0]   err_code;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy = 1'b0;
  logic [7:0]   rx_data;
  logic         rx_ready;

  logic [7:0] exp_tx[$];
  resp_t      exp_resp[$];

  int assertions = 0;
  int failures = 0;
  int cycle = 0;
  int tx_strobes = 0;
  int ct_valids = 0;
  int busy_falls = 0;
  int last_strobe_cycle = 0;
  int last_resp_cycle = 0;
  int last_rx_cycle = 0;

  simpleserial_host #(.RESP_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .load_key(load_key), .pt(pt),
    .start(start), .busy(busy), .ct(ct), .ct_valid(ct_valid), .err(err),
    .err_code(err_code), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // UART transmitter model: busy for 10 cycles after each strobe
  initial begin
    int cnt;
    logic s;
    cnt = 0;
    forever begin
      @(negedge clk);
      s = tx_start;
      @(posedge clk);
      #1;
      if (s) cnt = 10;
      else if (cnt > 0) cnt--;
      tx_busy = (cnt != 0);
    end
  end

  // Monitor: pops expectations whenever the DUT strobes a byte or a result
  initial begin
    logic  prev_start;
    logic  prev_busy;
    resp_t e;
    prev_start = 1'b0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_strobes++;
        last_strobe_cycle = cycle;
        checkOutput("tx_start back-to-back", 128'(prev_start), 128'd0);
        checkOutput("tx strobe expected", 128'(exp_tx.size() != 0), 128'd1);
        if (exp_tx.size() != 0) checkOutput("tx_data", 128'(tx_data), 128'(exp_tx.pop_front()));
      end
      prev_start = tx_start;
      if (ct_valid || err) begin
        last_resp_cycle = cycle;
        if (ct_valid) ct_valids++;
        checkOutput("ct_valid with err", 128'(ct_valid && err), 128'd0);
        checkOutput("busy low at result", 128'(busy), 128'd0);
        checkOutput("result expected", 128'(exp_resp.size() != 0), 128'd1);
        if (exp_resp.size() != 0) begin
          e = exp_resp.pop_front();
          checkOutput("result is err", 128'(err), 128'(e.is_err));
          if (e.is_err) checkOutput("err_code", 128'(err_code), 128'(e.code));
          else          checkOutput("ct", ct, e.ct);
        end
      end
      if (prev_busy && !busy) busy_falls++;
      prev_busy = busy;
    end
  end

  task automatic pushString(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
  endtask

  task automatic pushResp(input logic is_err, input logic [1:0] code, input logic [127:0] c);
    resp_t r;
    r.is_err = is_err;
    r.code   = code;
    r.ct     = c;
    exp_resp.push_back(r);
  endtask

  task automatic applyStimulus(input logic lk, input logic st,
                               input logic [127:0] k, input logic [127:0] p);
    @(posedge clk);
    #1;
    load_key = lk;
    start    = st;
    key      = k;
    pt       = p;
    @(posedge clk);
    #1;
    load_key = 1'b0;
    start    = 1'b0;
  endtask

  task automatic sendReply(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk);
      #1;
      rx_data  = s[i];
      rx_ready = 1'b1;
      last_rx_cycle = cycle;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic waitTx(input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("tx queue drained", 128'(exp_tx.size()), 128'd0);
  endtask

  task automatic waitResp(input int budget);
    int n = 0;
    while (exp_resp.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("result queue drained", 128'(exp_resp.size()), 128'd0);
  endtask

  // Directed sequence of transactions
  initial begin
    string s;
    int    n;
    int    strobes_before, valids_before, falls_before;
    rst_n = 1'b0; load_key = 1'b0; start = 1'b0; key = '0; pt = '0;
    rx_data = 8'h00; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 128'(busy), 128'd0);
    checkOutput("reset ct", ct, 128'd0);
    checkOutput("reset ct_valid", 128'(ct_valid), 128'd0);
    checkOutput("reset err", 128'(err), 128'd0);
    checkOutput("reset err_code", 128'(err_code), 128'd0);
    checkOutput("reset tx_start", 128'(tx_start), 128'd0);
    checkOutput("reset tx_data", 128'(tx_data), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] key load");
    strobes_before = tx_strobes;
    valids_before  = ct_valids;
    pushString("k000102030405060708090a0b0c0d0e0f\n");
    applyStimulus(1'b1, 1'b0, KEY, '0);
    checkOutput("busy after accept", 128'(busy), 128'd1);
    waitTx(1000);
    #1;
    checkOutput("key busy after last strobe", 128'(busy), 128'd0);
    checkOutput("key strobe count", 128'(tx_strobes - strobes_before), 128'd34);
    repeat (5) @(posedge clk);
    checkOutput("key no ct_valid", 128'(ct_valids - valids_before), 128'd0);

    $display("[TB] encrypt round trip");
    valids_before = ct_valids;
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b0, 2'd0, CT1);
    applyStimulus(1'b0, 1'b1, '0, PT);
    waitTx(1000);
    sendReply("r69c4e0d86a7b0430d8cdb78070b4c55a\n", 1);
    waitResp(50);
    checkOutput("ct_valid latency", 128'(last_resp_cycle - last_rx_cycle), 128'd1);
    checkOutput("round trip ct", ct, CT1);
    checkOutput("round trip one ct_valid", 128'(ct_valids - valids_before), 128'd1);

    $display("[TB] simultaneous key and start");
    falls_before = busy_falls;
    pushString("k000102030405060708090a0b0c0d0e0f\n");
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b0, 2'd0, CT2);
    applyStimulus(1'b1, 1'b1, KEY, PT);
    waitTx(2000);
    sendReply("r0123456789abcdeffedcba9876543210\n", 0);
    waitResp(50);
    checkOutput("simultaneous ct", ct, CT2);
    checkOutput("single busy interval", 128'(busy_falls - falls_before), 128'd1);

    $display("[TB] bad hex digit");
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b1, 2'd1, '0);
    applyStimulus(1'b0, 1'b1, '0, PT);
    waitTx(1000);
    sendReply("r12G", 1);
    waitResp(50);
    checkOutput("ct kept after bad hex", ct, CT2);

    $display("[TB] missing newline");
    s = "r";
    for (int i = 0; i < 32; i++) s = {s, "f"};
    s = {s, "x"};
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b1, 2'd2, '0);
    applyStimulus(1'b0, 1'b1, '0, PT);
    waitTx(1000);
    sendReply(s, 0);
    waitResp(50);
    checkOutput("ct kept after missing newline", ct, CT2);

    $display("[TB] response timeout");
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b1, 2'd3, '0);
    applyStimulus(1'b0, 1'b1, '0, PT);
    waitTx(1000);
    waitResp(int'(RT) + 50);
    checkOutput("timeout cycle", 128'(last_resp_cycle - last_strobe_cycle), 128'(int'(RT) + 1));
    checkOutput("ct kept after timeout", ct, CT2);
    repeat (5) @(posedge clk);
    checkOutput("err_code held", 128'(err_code), 128'd3);

    $display("[TB] noise and uppercase reply");
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b0, 2'd0, CT1);
    applyStimulus(1'b0, 1'b1, '0, PT);
    repeat (20) @(posedge clk);
    sendReply("r0\n", 2);
    checkOutput("noise sent during tx", 128'(exp_tx.size() != 0), 128'd1);
    waitTx(1000);
    sendReply("zz\nr69C4E0D86A7B0430D8CDB78070B4C55A\n", 0);
    waitResp(50);
    checkOutput("uppercase ct", ct, CT1);
    checkOutput("err_code held over success", 128'(err_code), 128'd3);

    $display("[TB] reset mid-frame");
    pushString("p00112233445");
    applyStimulus(1'b0, 1'b1, '0, PT);
    waitTx(1000);
    n = 0;
    while (!tx_start && n < 2000) begin
      #1;
      n++;
    end
    checkOutput("mid-frame strobe reached", 128'(tx_start), 128'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async tx_start drop", 128'(tx_start), 128'd0);
    checkOutput("mid reset busy", 128'(busy), 128'd0);
    checkOutput("mid reset ct", ct, 128'd0);
    checkOutput("mid reset err_code", 128'(err_code), 128'd0);
    checkOutput("mid reset tx_data", 128'(tx_data), 128'd0);
    checkOutput("mid reset ct_valid", 128'(ct_valid), 128'd0);
    checkOutput("mid reset err", 128'(err), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    strobes_before = tx_strobes;
    repeat (20) @(posedge clk);
    checkOutput("no strobes after reset", 128'(tx_strobes - strobes_before), 128'd0);
    pushString("p00112233445566778899aabbccddeeff\n");
    pushResp(1'b0, 2'd0, CT1);
    applyStimulus(1'b0, 1'b1, '0, PT);
    waitTx(1000);
    sendReply("r69c4e0d86a7b0430d8cdb78070b4c55a\n", 0);
    waitResp(50);
    checkOutput("post reset ct", ct, CT1);

    repeat (5) @(posedge clk);
    checkOutput("final tx queue empty", 128'(exp_tx.size()), 128'd0);
    checkOutput("final result queue empty", 128'(exp_resp.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
